fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Consumer-side adapter for `shift_register_fifo`. It pops words from the FIFO's push/pop interface and re-presents them downstream on a registered valid/ready stream. A two-entry output buffer gives one word per cycle with no combinational path from `out_ready` to `fifo_pop`, and `fifo_pop` is never issued while the FIFO is empty. It sits between any `shift_register_fifo` instance and a back-pressuring consumer, and also counts delivered beats.

## Interface
- `WIDTH`, 8, data width; must match the FIFO's `WIDTH`.
- `CNTWID`, 16, width of the delivered-beat counter.
- `clk`  in  1  the only clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset. Asserted together with the FIFO's `rst`.
- `fifo_empty`  in  1  FIFO `empty`.
- `fifo_data`  in  WIDTH  FIFO `data_out` (head entry; valid when `fifo_empty`=0).
- `fifo_pop`  out  1  FIFO `pop`; combinational from registered state and `fifo_empty` only.
- `flush`  in  1  discard all buffered words.
- `out_valid`  out  1  registered; buffer holds at least one word.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  WIDTH  registered; always entry0.
- `beats`  out  CNTWID  registered count of completed handshakes.

## Operation
- Storage:
  - entry0 is the head, driven on `out_data`; entry1 is the skid entry.
  - Occupancy state `occ` ∈ {OCC0, OCC1, OCC2}.
- `out_valid` = (`occ` != OCC0).
- xfer = `out_valid` & `out_ready`.
- `fifo_pop` = !`rst` & !`flush` & !`fifo_empty` & (`occ` != OCC2).
  - On a pop cycle, `fifo_data` is captured at the same edge the FIFO advances its head.
- Transitions (p = `fifo_pop`, x = xfer), with `flush`=0:
  - OCC0: p → OCC1, entry0←`fifo_data`; otherwise stay.
  - OCC1:
    - p&x → OCC1, entry0←`fifo_data`.
    - p&!x → OCC2, entry1←`fifo_data`.
    - !p&x → OCC0.
    - !p&!x → stay.
  - OCC2: x → OCC1, entry0←entry1; !x → stay. p is always 0 in OCC2.
- `flush`=1:
  - Next `occ`=OCC0; `fifo_pop`=0.
  - A handshake completing in the flush cycle counts as delivered; all other buffered words are dropped.
  - Entry contents are don't-care after flush. `out_data` holds its value; it is not zeroed.
- `beats` increments by 1 on every xfer, including during flush. It wraps modulo 2^CNTWID with no saturation.
- Entries are loaded only on the capture events above, so `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- Word order out equals FIFO pop order; no word is duplicated or skipped except those discarded by flush.

## Timing
- Reset: `occ`=OCC0, `out_valid`=0, `out_data`=0, entries=0, `beats`=0, `fifo_pop`=0 throughout reset.
- Reset mid-operation discards buffered words on the next edge. The FIFO is reset in the same cycle, so no word is orphaned.
- Latency: FIFO non-empty in cycle N with the buffer empty gives `fifo_pop`=1 in N and `out_valid`=1 in N+1.
- Throughput: with `out_ready` held 1 and the FIFO non-empty, steady state is OCC1 with one pop and one xfer per cycle.
- Back-pressure: `out_ready` low at most fills OCC2. Popping stops the cycle OCC2 is reached.
- Simultaneous flush + `fifo_empty` falling: no pop that cycle; popping resumes the next cycle.

## Structure
- Shared package `fifo_pkg`:
  - `occ_t` enum {OCC0, OCC1, OCC2}.
  - Default `WIDTH`, default `CNTWID`.
- Sub-module: the existing `FF` register cell (`WIDTH`, `INIT`=0, `rst`, `clk`, `en`, `D`, `Q`), instantiated once each for entry0 and entry1, with enables from the transition logic.
- `occ` and `beats` are plain registers in the top module.

## Test plan
- Reset, then FIFO pushes 0x11, 0x22, 0x33 with `out_ready`=1:
  - `out_data` sequence 0x11, 0x22, 0x33 on consecutive cycles, first valid 1 cycle after the first pop.
  - `beats`=3.
  - `fifo_pop` never asserted while `fifo_empty`=1.
- Back-pressure:
  - FIFO holds 0xA0..0xA4; `out_ready`=0 for 5 cycles, then 1.
  - Exactly 2 pops while stalled (OCC2); `out_data` held at 0xA0.
  - Release delivers 0xA0..0xA4 in order, one per cycle.
- Random `out_ready` (50%) over 200 pushes:
  - Output order matches push order.
  - `beats`=200.
  - No pop when empty; FIFO never over-popped.
- Flush:
  - In OCC2 holding 0x01/0x02, assert `flush` with `out_ready`=1.
  - 0x01 counted (`beats`+1); 0x02 dropped; `out_valid`=0 the next cycle; no pop in the flush cycle.
- Reset mid-stream:
  - Assert `rst` while in OCC1.
  - Next cycle `out_valid`=0, `out_data`=0, `beats`=0; `fifo_pop`=0 during reset.
- Counter wrap:
  - `CNTWID`=4, 17 transfers.
  - `beats`=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO consumer-side adapter.
//   occ_t          : occupancy of the two-entry output buffer
//   DEF_WIDTH      : default data width (matches shift_register_fifo)
//   DEF_CNTWID     : default width of the delivered-beat counter
//   occ_has_word() : true when the buffer holds at least one word
// ----------------------------------------------------------------------------
package fifo_pkg;

   typedef enum logic [1:0] {
      OCC0 = 2'd0,
      OCC1 = 2'd1,
      OCC2 = 2'd2
   } occ_t;

   localparam int DEF_WIDTH  = 8;
   localparam int DEF_CNTWID = 16;

   // A buffer with any occupancy other than OCC0 presents a word downstream.
   function automatic logic occ_has_word(input occ_t occ);
      return (occ != OCC0);
   endfunction

endpackage

// File: rtl/fifo_stream_reader_ff.sv
// ----------------------------------------------------------------------------
// FF
// Enabled register cell with synchronous active-high reset to INIT.
// Ports:
//   rst : synchronous reset, loads INIT
//   clk : clock
//   en  : load enable
//   D   : next value, loaded when en=1
//   Q   : registered value
// ----------------------------------------------------------------------------
module FF #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
   input  logic             rst,
   input  logic             clk,
   input  logic             en,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q
);

   // Storage: reset has priority over the load enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         Q <= INIT;
      end else if (en) begin
         Q <= D;
      end else begin
         Q <= Q;
      end
   end

endmodule

// File: rtl/fifo_stream_reader.sv
// ----------------------------------------------------------------------------
// fifo_stream_reader
// Pops words from a shift_register_fifo and re-presents them on a registered
// valid/ready stream through a two-entry buffer (head entry0, skid entry1),
// counting every completed downstream handshake.
// Ports:
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset (shared with the FIFO)
//   fifo_empty : FIFO empty flag
//   fifo_data  : FIFO head word, valid when fifo_empty=0
//   fifo_pop   : FIFO pop; depends only on registered state, rst, flush
//                and fifo_empty, never on out_ready
//   flush      : drop all buffered words (a handshake in this cycle counts)
//   out_valid  : registered, buffer holds at least one word
//   out_ready  : downstream accepts
//   out_data   : registered, always entry0
//   beats      : registered count of completed handshakes, wraps
// ----------------------------------------------------------------------------
module fifo_stream_reader
   import fifo_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int CNTWID = DEF_CNTWID
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fifo_empty,
   input  logic [WIDTH-1:0]  fifo_data,
   output logic              fifo_pop,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic [CNTWID-1:0] beats
);

   occ_t              occ_q;
   occ_t              occ_d;
   logic              out_valid_q;
   logic              out_valid_d;
   logic [CNTWID-1:0] beats_q;
   logic [CNTWID-1:0] beats_d;

   logic              pop_s;
   logic              xfer_s;
   logic              entry0_en_s;
   logic              entry1_en_s;
   logic [WIDTH-1:0]  entry0_in_s;
   logic [WIDTH-1:0]  entry0_q;
   logic [WIDTH-1:0]  entry1_q;

   // Pop only when there is room; OCC2 blocks popping so that out_ready
   // never reaches fifo_pop combinationally.
   assign pop_s  = (!rst) && (!flush) && (!fifo_empty) && (occ_q != OCC2);
   assign xfer_s = out_valid_q && out_ready;

   // Occupancy transitions and entry load selects.
   always_comb begin
      occ_d       = occ_q;
      entry0_en_s = 1'b0;
      entry1_en_s = 1'b0;
      entry0_in_s = fifo_data;
      if (flush) begin
         // Buffered words are dropped; entries keep their old contents so
         // out_data holds its last value.
         occ_d = OCC0;
      end else begin
         case (occ_q)
            OCC0: begin
               if (pop_s) begin
                  occ_d       = OCC1;
                  entry0_en_s = 1'b1;
               end else begin
                  occ_d = OCC0;
               end
            end
            OCC1: begin
               if (pop_s && xfer_s) begin
                  occ_d       = OCC1;
                  entry0_en_s = 1'b1;
               end else if (pop_s) begin
                  // Head is stalled: the new word goes to the skid entry.
                  occ_d       = OCC2;
                  entry1_en_s = 1'b1;
               end else if (xfer_s) begin
                  occ_d = OCC0;
               end else begin
                  occ_d = OCC1;
               end
            end
            OCC2: begin
               if (xfer_s) begin
                  // Skid word moves up to the head.
                  occ_d       = OCC1;
                  entry0_en_s = 1'b1;
                  entry0_in_s = entry1_q;
               end else begin
                  occ_d = OCC2;
               end
            end
            default: begin
               occ_d = OCC0;
            end
         endcase
      end
   end

   // Valid tracks the next occupancy so it is available as a flop output.
   always_comb begin
      out_valid_d = occ_has_word(occ_d);
   end

   // Beat counter: a handshake in a flush cycle still counts; wraps freely.
   always_comb begin
      if (xfer_s) begin
         beats_d = beats_q + {{(CNTWID-1){1'b0}}, 1'b1};
      end else begin
         beats_d = beats_q;
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q       <= OCC0;
         out_valid_q <= 1'b0;
         beats_q     <= {CNTWID{1'b0}};
      end else begin
         occ_q       <= occ_d;
         out_valid_q <= out_valid_d;
         beats_q     <= beats_d;
      end
   end

   FF #(
      .WIDTH (WIDTH),
      .INIT  ({WIDTH{1'b0}})
   ) u_entry0 (
      .rst (rst),
      .clk (clk),
      .en  (entry0_en_s),
      .D   (entry0_in_s),
      .Q   (entry0_q)
   );

   FF #(
      .WIDTH (WIDTH),
      .INIT  ({WIDTH{1'b0}})
   ) u_entry1 (
      .rst (rst),
      .clk (clk),
      .en  (entry1_en_s),
      .D   (fifo_data),
      .Q   (entry1_q)
   );

   assign fifo_pop  = pop_s;
   assign out_valid = out_valid_q;
   assign out_data  = entry0_q;
   assign beats     = beats_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ----------------------------------------------------------------------------
// tb_fifo_stream_reader
// Directed bench for fifo_stream_reader with a queue-based FIFO model.
// A cycle table covers streaming, back-pressure, flush and mid-stream reset;
// hand-written sequences cover random ready and the counter wrap.
// ----------------------------------------------------------------------------
module tb_fifo_stream_reader;

   logic        clk;
   logic        rst;
   logic        fifo_empty;
   logic [7:0]  fifo_data;
   logic        fifo_pop;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [15:0] beats;

   // Second instance with a 4-bit counter, fed by an always-full FIFO.
   logic        fifo_pop_w;
   logic        out_valid_w;
   logic        out_ready_w;
   logic [7:0]  out_data_w;
   logic [3:0]  beats_w;

   fifo_stream_reader #(.WIDTH(8), .CNTWID(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_pop   (fifo_pop),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .beats      (beats)
   );

   fifo_stream_reader #(.WIDTH(8), .CNTWID(4)) dut_w (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (1'b0),
      .fifo_data  (8'hC3),
      .fifo_pop   (fifo_pop_w),
      .flush      (1'b0),
      .out_valid  (out_valid_w),
      .out_ready  (out_ready_w),
      .out_data   (out_data_w),
      .beats      (beats_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        flush;
      logic        ready;
      logic        push;
      logic [7:0]  pdata;
      logic        exp_pop;
      logic        exp_valid;
      logic [7:0]  exp_data;
      logic [15:0] exp_beats;
   } vec_t;

   vec_t        vecs[26];
   logic [7:0]  fq[$];
   logic [7:0]  recv[$];
   int          n_vec;
   int          n_bad;
   int          pop_viol;

   task automatic set_vec(input int i, input logic r, input logic f, input logic rd,
                          input logic ps, input logic [7:0] pd, input logic ep,
                          input logic ev, input logic [7:0] ed, input logic [15:0] eb);
      vecs[i].rst       = r;
      vecs[i].flush     = f;
      vecs[i].ready     = rd;
      vecs[i].push      = ps;
      vecs[i].pdata     = pd;
      vecs[i].exp_pop   = ep;
      vecs[i].exp_valid = ev;
      vecs[i].exp_data  = ed;
      vecs[i].exp_beats = eb;
   endtask

   // One clock cycle: drive at the negedge, sample 1 ns later, advance the
   // FIFO model on the rising edge, return at the next negedge.
   task automatic step(input logic r, input logic f, input logic rd,
                       output logic p, output logic v, output logic [7:0] d,
                       output logic [15:0] b);
      logic [7:0] tmp;
      rst        = r;
      flush      = f;
      out_ready  = rd;
      fifo_empty = (fq.size() == 0);
      fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
      #1;
      p = fifo_pop;
      v = out_valid;
      d = out_data;
      b = beats;
      if (p && fifo_empty) pop_viol++;
      @(posedge clk);
      if (r) begin
         fq.delete();
      end else begin
         if (p && fq.size() != 0) tmp = fq.pop_front();
         if (v && rd) recv.push_back(d);
      end
      @(negedge clk);
   endtask

   initial begin
      logic        p, v;
      logic [7:0]  d;
      logic [15:0] b;
      int          pushed;
      int          cyc;
      n_vec = 0; n_bad = 0; pop_viol = 0;
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0; out_ready_w = 1'b0;
      fifo_empty = 1'b1; fifo_data = 8'h00;

      //          rst   flush ready push  pdata  pop   valid data   beats
      // streaming 11,22,33
      set_vec( 0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'd0);
      set_vec( 1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 16'd0);
      set_vec( 2, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 8'h11, 16'd0);
      set_vec( 3, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 8'h22, 16'd1);
      set_vec( 4, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 16'd2);
      set_vec( 5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h33, 16'd3);
      // back-pressure A0..A4, stall 5 cycles
      set_vec( 6, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b1, 1'b0, 8'h33, 16'd3);
      set_vec( 7, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b1, 8'hA0, 16'd3);
      set_vec( 8, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 8'hA0, 16'd3);
      set_vec( 9, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 8'hA0, 16'd3);
      set_vec(10, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA4, 1'b0, 1'b1, 8'hA0, 16'd3);
      set_vec(11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA0, 16'd3);
      set_vec(12, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA1, 16'd4);
      set_vec(13, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA2, 16'd5);
      set_vec(14, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA3, 16'd6);
      set_vec(15, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA4, 16'd7);
      set_vec(16, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA4, 16'd8);
      // flush in OCC2 holding 01/02, FIFO goes non-empty in the flush cycle
      set_vec(17, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 8'hA4, 16'd8);
      set_vec(18, 1'b0, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 8'h01, 16'd8);
      set_vec(19, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1, 8'h01, 16'd8);
      set_vec(20, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 16'd9);
      set_vec(21, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 16'd9);
      set_vec(22, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 16'd10);
      // reset while in OCC1
      set_vec(23, 1'b0, 1'b0, 1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 8'h03, 16'd10);
      set_vec(24, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 8'h44, 16'd10);
      set_vec(25, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'd0);

      // initial reset, not checked
      step(1'b1, 1'b0, 1'b0, p, v, d, b);
      step(1'b1, 1'b0, 1'b0, p, v, d, b);

      for (int i = 0; i < 26; i++) begin
         if (vecs[i].push) fq.push_back(vecs[i].pdata);
         step(vecs[i].rst, vecs[i].flush, vecs[i].ready, p, v, d, b);
         n_vec++;
         if (p !== vecs[i].exp_pop || v !== vecs[i].exp_valid ||
             d !== vecs[i].exp_data || b !== vecs[i].exp_beats) begin
            n_bad++;
            $display("FAIL vec%0d: got pop=%b valid=%b data=%h beats=%0d, want pop=%b valid=%b data=%h beats=%0d",
                     i, p, v, d, b, vecs[i].exp_pop, vecs[i].exp_valid,
                     vecs[i].exp_data, vecs[i].exp_beats);
         end
      end

      // random ready over 200 pushes; FIFO model holds at most 4 words
      recv.delete();
      pushed = 0;
      cyc    = 0;
      while (recv.size() < 200 && cyc < 5000) begin
         if (pushed < 200 && fq.size() < 4) begin
            fq.push_back(8'(pushed) ^ 8'h5A);
            pushed++;
         end
         step(1'b0, 1'b0, 1'($urandom_range(0, 1)), p, v, d, b);
         cyc++;
      end
      n_vec++;
      if (recv.size() != 200) begin
         n_bad++;
         $display("FAIL rand_count: got %0d words, want 200", recv.size());
      end
      for (int i = 0; i < recv.size() && i < 200; i++) begin
         n_vec++;
         if (recv[i] !== (8'(i) ^ 8'h5A)) begin
            n_bad++;
            $display("FAIL rand_order[%0d]: got %h, want %h", i, recv[i], 8'(i) ^ 8'h5A);
         end
      end
      // let any residual handshake settle with ready low, then check count
      step(1'b0, 1'b0, 1'b0, p, v, d, b);
      n_vec++;
      if (beats !== 16'd200) begin
         n_bad++;
         $display("FAIL rand_beats: got %0d, want 200", beats);
      end

      // counter wrap on the 4-bit instance: it sits in OCC2 with ready low
      n_vec++;
      if (beats_w !== 4'd0) begin
         n_bad++;
         $display("FAIL wrap_start: got %0d, want 0", beats_w);
      end
      out_ready_w = 1'b1;
      for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, p, v, d, b);
      n_vec++;
      if (beats_w !== 4'd0) begin
         n_bad++;
         $display("FAIL wrap_16: got %0d, want 0", beats_w);
      end
      step(1'b0, 1'b0, 1'b0, p, v, d, b);
      out_ready_w = 1'b0;
      n_vec++;
      if (beats_w !== 4'd1) begin
         n_bad++;
         $display("FAIL wrap_17: got %0d, want 1", beats_w);
      end

      n_vec++;
      if (pop_viol != 0) begin
         n_bad++;
         $display("FAIL pop_when_empty: got %0d occurrences, want 0", pop_viol);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
